// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl
//   Sequencer around fp16_softmax for the NPU output stage. Gathers a stream
//   of FP16 neuron values into an IN_OUT_NUM-lane vector, then runs the
//   softmax through start, wait-for-valid and clear. It scans the softmax
//   outputs for the argmax and returns a 1-based class index on a
//   valid/ready result port. A watchdog ends the wait if the softmax never
//   asserts valid.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     neuron value handshake, in_data = FP16 value
//   sm_start_op, sm_clear one-cycle control pulses to fp16_softmax
//   sm_input_neuron_val   lane vector to softmax (lane k = [k*16 +: 16])
//   sm_output_neuron_val  softmax result vector, qualified by sm_valid
//   res_valid/res_ready   result handshake
//   res_class             argmax lane + 1, 0 when no output is positive
//   res_max               FP16 value of the winning lane
//   res_err               softmax timed out for this result
//   busy                  high whenever not collecting inputs
module softmax_seq_ctrl #(
  parameter int unsigned IN_OUT_NUM     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CW            = $clog2(IN_OUT_NUM + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_data,
  output logic                    sm_start_op,
  output logic                    sm_clear,
  output logic [IN_OUT_NUM*16-1:0] sm_input_neuron_val,
  input  logic [IN_OUT_NUM*16-1:0] sm_output_neuron_val,
  input  logic                    sm_valid,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CW-1:0]           res_class,
  output logic [15:0]             res_max,
  output logic                    res_err,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_SCAN,
    S_CLEAR,
    S_RESULT
  } state_t;

  localparam logic [CW-1:0] LAST_LANE = CW'(IN_OUT_NUM - 1);
  localparam logic [15:0]   WD_LAST   = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;        // load lane in LOAD, scan lane in SCAN
  logic [15:0]             wd;         // cycles spent in WAIT
  logic [IN_OUT_NUM*16-1:0] snap;      // softmax outputs captured on sm_valid
  logic [14:0]             best_key;
  logic [CW-1:0]           best_idx;
  logic [15:0]             best_val;
  logic                    err_q;
  logic                    last_lane;
  logic                    wd_expired;
  logic [15:0]             scan_val;
  logic [14:0]             scan_key;

  assign last_lane  = (cnt == LAST_LANE);
  assign wd_expired = (wd == WD_LAST);

  // Lane under scan and its compare key; negative values and zero both map
  // to key 0 so they can never win against a positive value.
  always_comb begin
    scan_val = '0;
    for (int unsigned k = 0; k < IN_OUT_NUM; k++) begin
      if (cnt == CW'(k)) scan_val = snap[k*16 +: 16];
    end
    scan_key = scan_val[15] ? '0 : scan_val[14:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    sm_start_op = 1'b0;
    sm_clear    = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && last_lane) state_nxt = S_START;
      end
      S_START: begin
        sm_start_op = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (sm_valid)        state_nxt = S_SCAN;
        else if (wd_expired) state_nxt = S_CLEAR;
      end
      S_SCAN: begin
        if (last_lane) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        sm_clear  = 1'b1;
        state_nxt = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt                 <= '0;
      wd                  <= '0;
      sm_input_neuron_val <= '0;
      snap                <= '0;
      best_key            <= '0;
      best_idx            <= '0;
      best_val            <= '0;
      err_q               <= 1'b0;
      res_class           <= '0;
      res_max             <= '0;
      res_err             <= 1'b0;
    end else begin
      wd <= (state == S_WAIT) ? wd + 1'b1 : '0;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            for (int unsigned k = 0; k < IN_OUT_NUM; k++) begin
              if (cnt == CW'(k)) sm_input_neuron_val[k*16 +: 16] <= in_data;
            end
            cnt <= last_lane ? '0 : cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (sm_valid) begin
            snap     <= sm_output_neuron_val;
            best_key <= '0;
            best_idx <= '0;
            best_val <= '0;
            err_q    <= 1'b0;
          end else if (wd_expired) begin
            best_key <= '0;
            best_idx <= '0;
            best_val <= '0;
            err_q    <= 1'b1;
          end
        end
        S_SCAN: begin
          // Strict compare keeps the lowest lane on ties.
          if (scan_key > best_key) begin
            best_key <= scan_key;
            best_idx <= cnt + 1'b1;
            best_val <= scan_val;
          end
          cnt <= last_lane ? '0 : cnt + 1'b1;
        end
        S_CLEAR: begin
          res_class <= best_idx;
          res_max   <= best_val;
          res_err   <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
module tb_softmax_seq_ctrl;
  localparam int unsigned N      = 10;
  localparam int unsigned TO     = 20;
  localparam int unsigned CW     = $clog2(N + 1);
  localparam int unsigned W      = N * 16;
  localparam int          SM_LAT = 5;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          sm_start_op;
  logic          sm_clear;
  logic [W-1:0]  sm_input_neuron_val;
  logic [W-1:0]  sm_output_neuron_val;
  logic          sm_valid;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_class;
  logic [15:0]   res_max;
  logic          res_err;
  logic          busy;

  softmax_seq_ctrl #(.IN_OUT_NUM(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_data             (in_data),
    .sm_start_op         (sm_start_op),
    .sm_clear            (sm_clear),
    .sm_input_neuron_val (sm_input_neuron_val),
    .sm_output_neuron_val(sm_output_neuron_val),
    .sm_valid            (sm_valid),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_class           (res_class),
    .res_max             (res_max),
    .res_err             (res_err),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int cls; logic [15:0] mx; logic err; } res_t;
  typedef struct { logic [W-1:0] vec; bit never; } sm_job_t;

  res_t    exp_q[$];
  res_t    exp_log[$];
  res_t    got_q[$];
  sm_job_t sm_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_q;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_note(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur (cycle %0d)", nm, cyc);
  endtask

  // Reference argmax: find the largest positive magnitude first, then the
  // lowest lane that holds it.
  function automatic res_t ref_argmax(input logic [W-1:0] v);
    res_t r;
    int   maxk;
    int   key[N];
    r.cls = 0; r.mx = '0; r.err = 1'b0;
    maxk = 0;
    for (int k = 0; k < N; k++) begin
      logic [15:0] x;
      x = v[k*16 +: 16];
      key[k] = x[15] ? 0 : int'(x[14:0]);
      if (key[k] > maxk) maxk = key[k];
    end
    if (maxk != 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (key[k] == maxk) begin
          r.cls = k + 1;
          r.mx  = v[k*16 +: 16];
        end
      end
    end
    return r;
  endfunction

  // ---------------- behavioural model + compare ----------------
  bit          exp_loading = 1'b1;
  bit          was_loading;
  int          acc = 0;
  logic [15:0] lane_m [N];
  int          exp_start = -1;
  int          exp_clear = -1;
  int          exp_rv = -1;
  bit          in_wait = 1'b0;
  bit          in_result = 1'b0;
  int          nres = 0;
  res_t        r_tmp;

  function automatic logic [W-1:0] pack_lanes();
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*16 +: 16] = lane_m[k];
    return v;
  endfunction

  task automatic model_reset();
    exp_loading = 1'b1;
    acc = 0;
    for (int k = 0; k < N; k++) lane_m[k] = '0;
    exp_start = -1; exp_clear = -1; exp_rv = -1;
    in_wait = 1'b0; in_result = 1'b0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_q) begin
      model_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_sm_start_op", sm_start_op, 0);
      chk("rst_sm_clear", sm_clear, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_class", res_class, 0);
      chk("rst_res_max", res_max, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_lanes", sm_input_neuron_val, 0);
    end else begin
      if (cyc == exp_rv) in_result = 1'b1;
      chk("in_ready", in_ready, exp_loading);
      chk("busy", busy, !exp_loading);
      chk("sm_start_op", sm_start_op, cyc == exp_start);
      chk("sm_clear", sm_clear, cyc == exp_clear);
      chk("res_valid", res_valid, in_result);
      chk("lanes", sm_input_neuron_val, pack_lanes());
      if (in_result) begin
        if (exp_q.size() == 0) fail_note("res_expected_present");
        else begin
          chk("res_class", res_class, exp_q[0].cls);
          chk("res_max", res_max, exp_q[0].mx);
          chk("res_err", res_err, exp_q[0].err);
        end
      end
    end
    was_loading = exp_loading;
    if (!rst_q) begin
      if (in_wait) begin
        if (sm_valid) begin
          in_wait   = 1'b0;
          exp_clear = cyc + N + 1;
          exp_rv    = cyc + N + 2;
          r_tmp     = ref_argmax(sm_output_neuron_val);
          exp_q.push_back(r_tmp);
          exp_log.push_back(r_tmp);
        end else if (cyc == exp_start + int'(TO)) begin
          in_wait   = 1'b0;
          exp_clear = cyc + 1;
          exp_rv    = cyc + 2;
          r_tmp.cls = 0; r_tmp.mx = '0; r_tmp.err = 1'b1;
          exp_q.push_back(r_tmp);
          exp_log.push_back(r_tmp);
        end
      end
      if (cyc == exp_start) in_wait = 1'b1;
      if (in_result && res_ready) begin
        r_tmp.cls = int'(res_class); r_tmp.mx = res_max; r_tmp.err = res_err;
        got_q.push_back(r_tmp);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        in_result   = 1'b0;
        exp_loading = 1'b1;
        nres++;
      end
    end
    if (was_loading && in_valid) begin
      lane_m[acc] = in_data;
      acc++;
      if (acc == N) begin
        acc = 0;
        exp_loading = 1'b0;
        exp_start = cyc + 1;
      end
    end
  end

  // ---------------- fp16_softmax stand-in ----------------
  sm_job_t sm_job;
  bit      sm_abort;
  int      sm_n;

  initial begin
    sm_valid = 1'b0;
    sm_output_neuron_val = '0;
    forever begin
      @(negedge clk);
      if (sm_start_op && !rst_q) begin
        if (sm_q.size() > 0) sm_job = sm_q.pop_front();
        else begin sm_job.vec = '0; sm_job.never = 1'b1; end
        if (!sm_job.never) begin
          sm_abort = 1'b0;
          for (int i = 0; i < SM_LAT; i++) begin
            @(posedge clk);
            if (reset) begin sm_abort = 1'b1; break; end
          end
          if (!sm_abort) begin
            #1;
            sm_valid = 1'b1;
            sm_output_neuron_val = sm_job.vec;
            sm_n = 0;
            do begin @(negedge clk); sm_n++; end while (!(sm_clear || rst_q) && sm_n < 100);
            @(posedge clk); #1;
            sm_valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] vin [N];
  logic [W-1:0] vout;

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [15:0] d, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin @(negedge clk); n++; end while (!in_ready && n < 300);
    if (!in_ready) fail_note("in_ready_wait");
    sync();
    in_valid = 1'b0;
    repeat (gap) sync();
  endtask

  task automatic send_vec(input int gap);
    for (int k = 0; k < N; k++) put(vin[k], gap);
  endtask

  task automatic set_out(input logic [15:0] base, input int win, input logic [15:0] wv);
    for (int k = 0; k < N; k++) vout[k*16 +: 16] = (k == win) ? wv : base;
  endtask

  task automatic push_job(input bit never);
    sm_job_t j;
    j.vec = vout;
    j.never = never;
    sm_q.push_back(j);
  endtask

  task automatic wait_res(input int target);
    int n;
    n = 0;
    while (nres < target && n < 400) begin @(negedge clk); n++; end
    if (nres < target) fail_note("result_wait");
    sync();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sync();
    reset = 1'b0;
  endtask

  task automatic check_last(input string nm, input int cls, input logic [15:0] mx, input logic err);
    if (got_q.size() == 0) fail_note({nm, "_present"});
    else begin
      chk({nm, "_class"}, got_q[got_q.size()-1].cls, cls);
      chk({nm, "_max"}, got_q[got_q.size()-1].mx, mx);
      chk({nm, "_err"}, got_q[got_q.size()-1].err, err);
    end
  endtask

  task automatic check_model(input string nm, input int cls, input logic [15:0] mx);
    if (exp_log.size() == 0) fail_note({nm, "_present"});
    else begin
      chk({nm, "_class"}, exp_log[exp_log.size()-1].cls, cls);
      chk({nm, "_max"}, exp_log[exp_log.size()-1].mx, mx);
    end
  endtask

  int win_cls [5] = '{1, 3, 5, 8, 10};
  int n_wait;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
    repeat (3) sync();
    reset = 1'b0;

    // lane 6 largest input, lane 6 largest softmax output
    for (int k = 0; k < N; k++) vin[k] = (k == 6) ? 16'h4000 : 16'h3C00;
    set_out(16'h2C00, 6, 16'h3A00); push_job(1'b0);
    send_vec(0); wait_res(1);
    check_last("basic", 7, 16'h3A00, 1'b0);
    check_model("basic_model", 7, 16'h3A00);

    // all-equal outputs: lowest lane wins
    set_out(16'h2E66, 0, 16'h2E66); push_job(1'b0);
    send_vec(0); wait_res(2);
    check_last("tie", 1, 16'h2E66, 1'b0);
    check_model("tie_model", 1, 16'h2E66);

    // zero and negative outputs only
    for (int k = 0; k < N; k++)
      vout[k*16 +: 16] = (k % 3 == 0) ? 16'h0000 : ((k % 3 == 1) ? 16'h8000 : 16'hBC00);
    push_job(1'b0);
    send_vec(0); wait_res(3);
    check_last("nonpos", 0, 16'h0000, 1'b0);

    // gapped input, result back-pressured for 7 cycles
    for (int k = 0; k < N; k++) vin[k] = 16'h4000 + 16'(k * 16'h0100);
    set_out(16'h2000, 3, 16'h3800); push_job(1'b0);
    res_ready = 1'b0;
    send_vec(1);
    n_wait = 0;
    while (!res_valid && n_wait < 200) begin @(negedge clk); n_wait++; end
    if (!res_valid) fail_note("stall_res_valid");
    sync();
    repeat (6) sync();
    res_ready = 1'b1;
    wait_res(4);
    check_last("stall", 4, 16'h3800, 1'b0);

    // softmax never responds
    push_job(1'b1);
    send_vec(0); wait_res(5);
    check_last("timeout", 0, 16'h0000, 1'b1);
    set_out(16'h2000, 2, 16'h3000); push_job(1'b0);
    send_vec(0); wait_res(6);
    check_last("after_timeout", 3, 16'h3000, 1'b0);

    // reset during WAIT, then reset after 4 of 10 inputs
    set_out(16'h1000, 5, 16'h3555); push_job(1'b0);
    send_vec(0);
    n_wait = 0;
    do begin @(negedge clk); n_wait++; end while (!sm_start_op && n_wait < 50);
    if (!sm_start_op) fail_note("start_before_reset");
    sync();
    repeat (2) sync();
    do_reset();
    for (int k = 0; k < 4; k++) put(16'h5000 + 16'(k), 0);
    do_reset();
    set_out(16'h1000, 5, 16'h3555); push_job(1'b0);
    send_vec(0); wait_res(7);
    check_last("post_reset", 6, 16'h3555, 1'b0);

    // back-to-back vectors, winners at lanes 1,3,5,8,10
    for (int i = 0; i < 5; i++) begin
      set_out(16'h2400, win_cls[i] - 1, 16'h3800 + 16'(i));
      push_job(1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < N; k++) vin[k] = 16'h3000 + 16'(i * 16 + k);
      send_vec(0);
    end
    wait_res(12);
    if (got_q.size() < 12) fail_note("b2b_results");
    else begin
      for (int i = 0; i < 5; i++) begin
        chk("b2b_class", got_q[7 + i].cls, win_cls[i]);
        chk("b2b_max", got_q[7 + i].mx, 16'h3800 + 16'(i));
      end
    end

    repeat (5) sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
